// File: rtl/load_hazard_if.sv
// Load-use hazard bundle between the ID/EX pipeline view and the hazard unit.
// The hazard unit is the slave; the pipeline side drives it as master.
interface load_hazard_if #(
  parameter int REG_W = 5,
  parameter int CNT_W = 16
);
  logic             memr_ie;
  logic             fw_ie;
  logic [REG_W-1:0] rd_ie;
  logic [REG_W-1:0] rs1_id;
  logic [REG_W-1:0] rs2_id;
  logic [REG_W-1:0] rs3_id;
  logic [2:0]       src_use;
  logic [2:0]       src_float;
  logic             memw_id;
  logic             dmem_ready;
  logic             flush;
  logic             bubble;
  logic             id_stall;
  logic             pc_stall;
  logic [CNT_W-1:0] stall_cnt;

  modport master (
    output memr_ie, fw_ie, rd_ie,
    output rs1_id, rs2_id, rs3_id,
    output src_use, src_float,
    output memw_id, dmem_ready, flush,
    input  bubble, id_stall, pc_stall,
    input  stall_cnt
  );

  modport slave (
    input  memr_ie, fw_ie, rd_ie,
    input  rs1_id, rs2_id, rs3_id,
    input  src_use, src_float,
    input  memw_id, dmem_ready, flush,
    output bubble, id_stall, pc_stall,
    output stall_cnt
  );
endinterface

// File: rtl/load_hazard_unit.sv
// Load-use hazard detector: stalls ID/PC and bubbles EX for LOAD_LAT cycles,
// extended while data memory is not ready; counts stalled cycles.
module load_hazard_unit #(
  parameter int REG_W    = 5,
  parameter int LOAD_LAT = 1,
  parameter int CNT_W    = 16
) (
  input logic         clk,
  input logic         rst_n,
  load_hazard_if.slave hz
);

  typedef enum logic [1:0] {
    IDLE,
    STALL,
    WAIT
  } state_t;

  localparam logic [3:0] LAT_M1 = 4'(LOAD_LAT - 1);

  state_t           state_q, state_d;
  logic [3:0]       rem_q, rem_d;
  logic [CNT_W-1:0] cnt_q;
  logic [REG_W-1:0] rs [3];
  logic [2:0]       match;
  logic             hazard;
  logic             stall_c;
  logic             stall;

  assign rs[0] = hz.rs1_id;
  assign rs[1] = hz.rs2_id;
  assign rs[2] = hz.rs3_id;

  // x0 is hardwired in the integer file, so it never carries a hazard
  always_comb begin
    match = '0;
    for (int i = 0; i < 3; i++) begin
      match[i] = hz.src_use[i]
               && (rs[i] == hz.rd_ie)
               && (hz.src_float[i] == hz.fw_ie)
               && (hz.fw_ie || (hz.rd_ie != '0));
    end
    if (hz.memw_id) match[1] = 1'b0;
  end

  assign hazard = hz.memr_ie && (|match);

  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    stall_c = 1'b0;
    if (hz.flush) begin
      state_d = IDLE;
      rem_d   = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          stall_c = hazard;
          if (hazard) begin
            if (LOAD_LAT > 1) begin
              state_d = STALL;
              rem_d   = LAT_M1;
            end else if (!hz.dmem_ready) begin
              state_d = WAIT;
            end
          end
        end
        STALL: begin
          stall_c = 1'b1;
          rem_d   = rem_q - 4'd1;
          if (rem_q == 4'd1) begin
            rem_d   = '0;
            state_d = hz.dmem_ready ? IDLE : WAIT;
          end
        end
        WAIT: begin
          stall_c = 1'b1;
          if (hz.dmem_ready) state_d = IDLE;
        end
        default: begin
          state_d = IDLE;
          rem_d   = '0;
        end
      endcase
    end
  end

  // Gate with rst_n so the outputs drop the instant reset asserts
  assign stall       = stall_c && rst_n;
  assign hz.bubble   = stall;
  assign hz.id_stall = stall;
  assign hz.pc_stall = stall;
  assign hz.stall_cnt = cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      rem_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      if (stall && (cnt_q != '1)) cnt_q <= cnt_q + 1'b1;
    end
  end

endmodule

// File: tb/tb_load_hazard_unit.sv
// Directed bench for load_hazard_unit: match table on a LOAD_LAT=1 instance,
// multi-cycle stall/flush/saturation/reset sequences on a LOAD_LAT=3 instance.
module tb_load_hazard_unit;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   exp_cnt1;

  always #5 clk = ~clk;

  load_hazard_if #(.REG_W(5), .CNT_W(16)) h1 ();
  load_hazard_if #(.REG_W(5), .CNT_W(4))  h3 ();

  load_hazard_unit #(.REG_W(5), .LOAD_LAT(1), .CNT_W(16)) u1 (
    .clk   (clk),
    .rst_n (rst_n),
    .hz    (h1)
  );

  load_hazard_unit #(.REG_W(5), .LOAD_LAT(3), .CNT_W(4)) u3 (
    .clk   (clk),
    .rst_n (rst_n),
    .hz    (h3)
  );

  typedef struct {
    logic       memr;
    logic       fw;
    logic       memw;
    logic       flush;
    logic [4:0] rd;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [4:0] rs3;
    logic [2:0] use_v;
    logic [2:0] flt;
    logic       exp;
  } vec_t;

  vec_t tv [14];

  task automatic check(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d want %0d", nm, act, exp);
    end
  endtask

  function automatic int outs1();
    return {h1.bubble, h1.id_stall, h1.pc_stall};
  endfunction

  function automatic int outs3();
    return {h3.bubble, h3.id_stall, h3.pc_stall};
  endfunction

  task automatic clr1();
    h1.memr_ie = 0; h1.fw_ie = 0; h1.rd_ie = 0;
    h1.rs1_id = 0; h1.rs2_id = 0; h1.rs3_id = 0;
    h1.src_use = 0; h1.src_float = 0;
    h1.memw_id = 0; h1.dmem_ready = 1; h1.flush = 0;
  endtask

  // Fixed integer rs1 hazard on x7 for the LOAD_LAT=3 instance
  task automatic drv3(input logic memr, input logic rdy, input logic fl);
    h3.fw_ie = 0; h3.rd_ie = 5'd7;
    h3.rs1_id = 5'd7; h3.rs2_id = 0; h3.rs3_id = 0;
    h3.src_use = 3'b001; h3.src_float = 0; h3.memw_id = 0;
    h3.memr_ie = memr; h3.dmem_ready = rdy; h3.flush = fl;
  endtask

  task automatic step3(input string nm, input logic memr,
                       input logic rdy, input logic fl, input logic exp);
    @(negedge clk);
    drv3(memr, rdy, fl);
    #1;
    check(nm, outs3(), exp ? 7 : 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 0;
    clr1();
    drv3(0, 1, 0);
    @(negedge clk);
    rst_n = 1;
  endtask

  initial begin
    tv = '{
      '{1, 0, 0, 0, 5'd5,  5'd5,  5'd0,  5'd0,  3'b001, 3'b000, 1},
      '{1, 0, 0, 0, 5'd0,  5'd0,  5'd0,  5'd0,  3'b001, 3'b000, 0},
      '{1, 1, 0, 0, 5'd5,  5'd5,  5'd0,  5'd0,  3'b001, 3'b000, 0},
      '{1, 1, 0, 0, 5'd5,  5'd5,  5'd0,  5'd0,  3'b001, 3'b001, 1},
      '{1, 0, 1, 0, 5'd5,  5'd3,  5'd5,  5'd0,  3'b010, 3'b000, 0},
      '{1, 0, 1, 0, 5'd5,  5'd5,  5'd0,  5'd0,  3'b001, 3'b000, 1},
      '{1, 0, 0, 0, 5'd5,  5'd3,  5'd5,  5'd0,  3'b010, 3'b000, 1},
      '{1, 1, 0, 0, 5'd9,  5'd0,  5'd0,  5'd9,  3'b100, 3'b000, 0},
      '{0, 0, 0, 0, 5'd5,  5'd5,  5'd0,  5'd0,  3'b001, 3'b000, 0},
      '{1, 0, 0, 0, 5'd5,  5'd5,  5'd5,  5'd5,  3'b000, 3'b000, 0},
      '{1, 0, 0, 1, 5'd5,  5'd5,  5'd0,  5'd0,  3'b001, 3'b000, 0},
      '{1, 1, 0, 0, 5'd0,  5'd0,  5'd0,  5'd0,  3'b001, 3'b001, 1},
      '{1, 1, 1, 0, 5'd9,  5'd0,  5'd0,  5'd9,  3'b100, 3'b100, 1},
      '{1, 0, 0, 0, 5'd12, 5'd4,  5'd12, 5'd0,  3'b010, 3'b010, 0}
    };

    // Outputs must be forced low during reset even with a live hazard
    clr1();
    drv3(1, 1, 0);
    h1.memr_ie = 1; h1.rd_ie = 5'd5; h1.rs1_id = 5'd5; h1.src_use = 3'b001;
    #2;
    check("rst_outs_u1", outs1(), 0);
    check("rst_outs_u3", outs3(), 0);
    check("rst_cnt_u1", int'(h1.stall_cnt), 0);
    check("rst_cnt_u3", int'(h3.stall_cnt), 0);
    @(negedge clk);
    clr1();
    drv3(0, 1, 0);
    rst_n = 1;

    exp_cnt1 = 0;
    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      h1.memr_ie = tv[i].memr; h1.fw_ie = tv[i].fw;
      h1.memw_id = tv[i].memw; h1.flush = tv[i].flush;
      h1.rd_ie = tv[i].rd; h1.rs1_id = tv[i].rs1;
      h1.rs2_id = tv[i].rs2; h1.rs3_id = tv[i].rs3;
      h1.src_use = tv[i].use_v; h1.src_float = tv[i].flt;
      h1.dmem_ready = 1;
      #1;
      check($sformatf("vec%0d_outs", i), outs1(), tv[i].exp ? 7 : 0);
      check($sformatf("vec%0d_cnt", i), int'(h1.stall_cnt), exp_cnt1);
      if (tv[i].exp) exp_cnt1++;
    end

    // LOAD_LAT=1 with memory late by two cycles: three stalled cycles
    @(negedge clk);
    clr1();
    h1.memr_ie = 1; h1.rd_ie = 5'd5; h1.rs1_id = 5'd5;
    h1.src_use = 3'b001; h1.dmem_ready = 0;
    #1 check("l1w_c0", outs1(), 7);
    @(negedge clk);
    h1.memr_ie = 0;
    #1 check("l1w_c1", outs1(), 7);
    @(negedge clk);
    h1.dmem_ready = 1;
    #1 check("l1w_c2", outs1(), 7);
    @(negedge clk);
    #1 check("l1w_c3", outs1(), 0);
    check("l1w_cnt", int'(h1.stall_cnt), exp_cnt1 + 3);

    // LOAD_LAT=3, memory low for two cycles at the end: five stalls
    do_reset();
    step3("l3w_c0", 1, 1, 0, 1);
    step3("l3w_c1", 0, 1, 0, 1);
    step3("l3w_c2", 0, 0, 0, 1);
    step3("l3w_c3", 0, 0, 0, 1);
    step3("l3w_c4", 0, 1, 0, 1);
    step3("l3w_c5", 0, 1, 0, 0);
    check("l3w_cnt", int'(h3.stall_cnt), 5);

    // Back-to-back: new hazard in the first IDLE cycle
    do_reset();
    step3("b2b_c0", 1, 1, 0, 1);
    step3("b2b_c1", 0, 1, 0, 1);
    step3("b2b_c2", 0, 1, 0, 1);
    step3("b2b_c3", 1, 1, 0, 1);
    step3("b2b_c4", 0, 1, 0, 1);
    step3("b2b_c5", 0, 1, 0, 1);
    step3("b2b_c6", 0, 1, 0, 0);
    check("b2b_cnt", int'(h3.stall_cnt), 6);

    // Flush in the second stall cycle
    do_reset();
    step3("fl_c0", 1, 1, 0, 1);
    step3("fl_c1", 0, 1, 1, 0);
    step3("fl_c2", 0, 1, 0, 0);
    check("fl_cnt", int'(h3.stall_cnt), 1);

    // Saturation at 15, then asynchronous reset mid-stall
    do_reset();
    step3("sat_c0", 1, 1, 0, 1);
    repeat (20) @(negedge clk);
    #1;
    check("sat_outs", outs3(), 7);
    check("sat_cnt", int'(h3.stall_cnt), 15);
    rst_n = 0;
    #1;
    check("arst_cnt", int'(h3.stall_cnt), 0);
    check("arst_outs", outs3(), 0);
    @(negedge clk);
    drv3(0, 1, 0);
    rst_n = 1;
    #1 check("rel_c0", outs3(), 0);
    @(negedge clk);
    #1 check("rel_c1", outs3(), 0);
    check("rel_cnt", int'(h3.stall_cnt), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
